// File: rtl/rrf_alloc_unit_pkg.sv
// Shared constants and pointer arithmetic for the rename-register allocator.
package rrf_alloc_unit_pkg;
  localparam int RRF_NUM        = 64;
  localparam int RRF_SEL        = 6;
  localparam int ROB_SEL        = RRF_SEL;
  localparam int DISPATCH_WIDTH = 2;
  localparam int COMMIT_WIDTH   = 2;

  typedef logic [RRF_SEL-1:0] rrf_ptr_t;
  typedef logic [RRF_SEL:0]   rrf_cnt_t;

  // Modulo-RRF_NUM add; the MSB of the result is the wrap carry.
  function automatic logic [RRF_SEL:0] ptr_add(input rrf_ptr_t ptr, input logic [1:0] inc);
    ptr_add = {1'b0, ptr} + {{(RRF_SEL-1){1'b0}}, inc};
  endfunction
endpackage

// File: rtl/rrf_alloc_unit_if.sv
// Dispatch/commit bus of the RRF allocator; flush signals exist only with RRF_FLUSH_EN.
interface rrf_alloc_unit_if;
  import rrf_alloc_unit_pkg::*;

  logic       req1_i;
  logic       req2_i;
  logic [1:0] comnum_i;
  rrf_ptr_t   dp1_addr_o;
  rrf_ptr_t   dp2_addr_o;
  logic       stall_o;
  rrf_cnt_t   freenum_o;
  rrf_ptr_t   rrfptr_o;
  rrf_ptr_t   comptr_o;
  logic       nextrrfcyc_o;
`ifdef RRF_FLUSH_EN
  logic       flush_i;
  rrf_ptr_t   flush_ptr_i;
`endif

  modport slave (
    input  req1_i, req2_i, comnum_i,
`ifdef RRF_FLUSH_EN
    input  flush_i, flush_ptr_i,
`endif
    output dp1_addr_o, dp2_addr_o, stall_o, freenum_o, rrfptr_o, comptr_o, nextrrfcyc_o
  );

  modport master (
    output req1_i, req2_i, comnum_i,
`ifdef RRF_FLUSH_EN
    output flush_i, flush_ptr_i,
`endif
    input  dp1_addr_o, dp2_addr_o, stall_o, freenum_o, rrfptr_o, comptr_o, nextrrfcyc_o
  );
endinterface

// File: rtl/rrf_alloc_unit.sv
// RRF/ROB entry allocator: grants 0-2 consecutive entries per cycle, reclaims on commit.
// Grant is same-cycle, all-or-nothing; optional mispredict rollback under RRF_FLUSH_EN.
module rrf_alloc_unit
  import rrf_alloc_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  rrf_alloc_unit_if.slave   bus
);

  rrf_ptr_t         rrfptr, comptr;
  rrf_cnt_t         freenum;
  logic             nextrrfcyc;

  logic [1:0]       reqcnt;
  logic [1:0]       alloc;
  logic             stall;
  logic [RRF_SEL:0] rrf_sum, com_sum;
  rrf_ptr_t         rrfptr_nxt, comptr_nxt;
  rrf_cnt_t         freenum_nxt;
  logic             cyc_nxt;
  rrf_cnt_t         used_cnt;

  assign reqcnt = {1'b0, bus.req1_i} + {1'b0, bus.req1_i & bus.req2_i};

  // Stall only looks at the registered free count; same-cycle commits are not credited.
`ifdef RRF_FLUSH_EN
  assign stall = ({{(RRF_SEL-1){1'b0}}, reqcnt} > freenum) | bus.flush_i;
`else
  assign stall = ({{(RRF_SEL-1){1'b0}}, reqcnt} > freenum);
`endif

  assign alloc = stall ? 2'd0 : reqcnt;

  always_comb begin
    rrf_sum     = ptr_add(rrfptr, alloc);
    com_sum     = ptr_add(comptr, bus.comnum_i);
    rrfptr_nxt  = rrf_sum[RRF_SEL-1:0];
    cyc_nxt     = nextrrfcyc ^ rrf_sum[RRF_SEL];
    comptr_nxt  = com_sum[RRF_SEL-1:0];
    freenum_nxt = freenum - {{(RRF_SEL-1){1'b0}}, alloc} + {{(RRF_SEL-1){1'b0}}, bus.comnum_i};
`ifdef RRF_FLUSH_EN
    // Rollback: everything between the new commit pointer and flush_ptr stays live.
    if (bus.flush_i) begin
      rrfptr_nxt  = bus.flush_ptr_i;
      freenum_nxt = rrf_cnt_t'(RRF_NUM) - {1'b0, rrf_ptr_t'(bus.flush_ptr_i - comptr_nxt)};
      cyc_nxt     = nextrrfcyc ^ (bus.flush_ptr_i < rrfptr);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrfptr     <= '0;
      comptr     <= '0;
      freenum    <= rrf_cnt_t'(RRF_NUM);
      nextrrfcyc <= 1'b0;
    end else begin
      rrfptr     <= rrfptr_nxt;
      comptr     <= comptr_nxt;
      freenum    <= freenum_nxt;
      nextrrfcyc <= cyc_nxt;
    end
  end

  assign used_cnt = rrf_cnt_t'(RRF_NUM) - freenum;

  // The ROB can never commit more entries than are currently in flight.
  assert property (@(posedge clk) disable iff (reset)
                   ({{(RRF_SEL-1){1'b0}}, bus.comnum_i} <= used_cnt));

  assign bus.dp1_addr_o   = rrfptr;
  assign bus.dp2_addr_o   = rrfptr + rrf_ptr_t'(1);
  assign bus.stall_o      = stall;
  assign bus.freenum_o    = freenum;
  assign bus.rrfptr_o     = rrfptr;
  assign bus.comptr_o     = comptr;
  assign bus.nextrrfcyc_o = nextrrfcyc;

endmodule
